// File: rtl/conv_pkg.sv
// Shared defaults and types for the time-shared 3x3 convolution MAC sequencer.
package conv_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ACC_W_DEF    = 32;
  localparam int TAPS_DEF     = 9;
  localparam int MULT_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  typedef logic [$clog2(TAPS_DEF)-1:0] tap_idx_t;

endpackage

// File: rtl/conv_valid_delay.sv
// Tap-issued flag pipeline matching the external multiplier latency, so each
// product is accumulated exactly in the cycle it appears on mult_p.
module conv_valid_delay #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout
);

  logic [STAGES-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_dout = r_pipe[STAGES-1];

endmodule

// File: rtl/conv_mac_sequencer.sv
// Issues the nine taps of a latched 3x3 window/filter pair to one external
// registered multiplier and accumulates the products into a signed result.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int TAPS     = TAPS_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [TAPS*DATA_W-1:0] i_win_data,
  input  logic [TAPS*DATA_W-1:0] i_filt_data,
  output logic [DATA_W-1:0]      o_mult_a,
  output logic [DATA_W-1:0]      o_mult_b,
  output logic                   o_mult_ce,
  input  logic [2*DATA_W-1:0]    i_mult_p,
  output logic [ACC_W-1:0]       o_result,
  output logic                   o_result_valid,
  input  logic                   i_result_ready,
  output logic                   o_busy
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int DRN_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(MULT_LAT - 1);

  conv_state_e            r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [DRN_W-1:0]       r_drn;
  logic [TAPS*DATA_W-1:0] r_win;
  logic [TAPS*DATA_W-1:0] r_filt;
  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       r_result;

  logic [DATA_W-1:0]      w_win_tap  [TAPS];
  logic [DATA_W-1:0]      w_filt_tap [TAPS];
  logic                   w_issue;
  logic                   w_prod_vld;
  logic [ACC_W-1:0]       w_prod_ext;
  logic [ACC_W-1:0]       w_acc_next;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      assign w_win_tap[gi]  = r_win[gi*DATA_W +: DATA_W];
      assign w_filt_tap[gi] = r_filt[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_issue = i_en & (r_state == ST_ISSUE);

  conv_valid_delay #(
    .STAGES (MULT_LAT)
  ) u_valid_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (i_en),
    .i_din  (w_issue),
    .o_dout (w_prod_vld)
  );

  assign w_prod_ext = {{(ACC_W-2*DATA_W){i_mult_p[2*DATA_W-1]}}, i_mult_p};
  assign w_acc_next = r_acc + (w_prod_vld ? w_prod_ext : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_drn    <= '0;
      r_win    <= '0;
      r_filt   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (i_en) begin
      r_acc <= w_acc_next;
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_win   <= i_win_data;
            r_filt  <= i_filt_data;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_drn   <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_drn <= r_drn + 1'b1;
          // The final product lands this cycle, so capture the sum including it.
          if (r_drn == LAST_DRN) begin
            r_result <= w_acc_next;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_result_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mult_a = '0;
    o_mult_b = '0;
    if (r_state == ST_ISSUE) begin
      o_mult_a = w_win_tap[r_idx];
      o_mult_b = w_filt_tap[r_idx];
    end
  end

  assign o_mult_ce      = i_en & ((r_state == ST_ISSUE) | (r_state == ST_DRAIN));
  assign o_in_ready     = (r_state == ST_IDLE);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_result_valid = (r_state == ST_DONE);
  assign o_result       = r_result;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Randomised bench for conv_mac_sequencer with a registered multiplier model
// and a sum-of-products reference.
module tb_conv_mac_sequencer;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int NT = 9;
  localparam int ML = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NT*DW-1:0]  win = '0;
  logic [NT*DW-1:0]  filt = '0;
  logic [DW-1:0]     mult_a;
  logic [DW-1:0]     mult_b;
  logic              mult_ce;
  logic [2*DW-1:0]   mult_p = '0;
  logic [AW-1:0]     result;
  logic              result_valid;
  logic              result_ready = 1'b1;
  logic              busy;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  conv_mac_sequencer #(
    .DATA_W   (DW),
    .ACC_W    (AW),
    .TAPS     (NT),
    .MULT_LAT (ML)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (en),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_win_data     (win),
    .i_filt_data    (filt),
    .o_mult_a       (mult_a),
    .o_mult_b       (mult_b),
    .o_mult_ce      (mult_ce),
    .i_mult_p       (mult_p),
    .o_result       (result),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: signed product, output register with clock enable
  always @(posedge clk) begin
    if (mult_ce) mult_p <= $signed(mult_a) * $signed(mult_b);
  end

  function automatic logic [AW-1:0] ref_sum(input logic [NT*DW-1:0] w, input logic [NT*DW-1:0] f);
    int s;
    s = 0;
    for (int k = 0; k < NT; k++) begin
      byte a;
      byte b;
      a = w[k*DW +: DW];
      b = f[k*DW +: DW];
      s += int'(a) * int'(b);
    end
    return AW'(s);
  endfunction

  function automatic logic [NT*DW-1:0] rand_vec();
    logic [NT*DW-1:0] v;
    for (int k = 0; k < NT; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Offers a pair at a negedge; returns in cycle t0+1 with in_valid dropped.
  task automatic send(input logic [NT*DW-1:0] w, input logic [NT*DW-1:0] f, output int t_acc);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    win = w;
    filt = f;
    in_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (result_valid !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({result_valid, busy, mult_ce, mult_a, mult_b, result} !== '0)
      $display("FAIL reset_outputs: got valid=%b busy=%b ce=%b a=%h b=%h res=%h, want all 0",
               result_valid, busy, mult_ce, mult_a, mult_b, result);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got in_ready=%b busy=%b, want 1/0", in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_basic;
    logic [NT*DW-1:0] w;
    logic [AW-1:0] exp;
    int t;
    for (int k = 0; k < NT; k++) w[k*DW +: DW] = (k % 2 == 1) ? 8'd1 : 8'd0;
    exp = ref_sum(w, w);
    send(w, w, t);
    for (int k = 0; k < NT; k++) begin
      n_checks++;
      if (mult_a !== w[k*DW +: DW] || mult_b !== w[k*DW +: DW] || mult_ce !== 1'b1 || busy !== 1'b1)
        $display("FAIL basic_tap%0d: got a=%h b=%h ce=%b busy=%b, want a=b=%h ce=1 busy=1",
                 k, mult_a, mult_b, mult_ce, busy, w[k*DW +: DW]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (mult_ce !== 1'b1 || mult_a !== '0 || result_valid !== 1'b0)
      $display("FAIL basic_drain: got ce=%b a=%h valid=%b, want 1/00/0", mult_ce, mult_a, result_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b1 || result !== exp || result !== 32'd4)
      $display("FAIL basic_result: got valid=%b result=%0d, want 1/%0d", result_valid, $signed(result), $signed(exp));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp)
      $display("FAIL basic_after: got valid=%b in_ready=%b result=%h, want 0/1/%h", result_valid, in_ready, result, exp);
    else n_pass++;
  endtask

  task automatic test_corners;
    logic [DW-1:0] pix [2];
    logic [DW-1:0] cof [2];
    logic [AW-1:0] want [2];
    logic [NT*DW-1:0] w;
    logic [NT*DW-1:0] f;
    int t;
    int c;
    pix[0] = 8'hFF; cof[0] = 8'h02; want[0] = 32'hFFFF_FFEE;
    pix[1] = 8'h80; cof[1] = 8'h80; want[1] = 32'h0002_4000;
    for (int i = 0; i < 2; i++) begin
      w = {NT{pix[i]}};
      f = {NT{cof[i]}};
      send(w, f, t);
      wait_valid(c);
      n_checks++;
      if (c !== 11 || result !== want[i] || result !== ref_sum(w, f))
        $display("FAIL corner%0d: got lat=%0d result=%h, want lat=11 result=%h", i, c, result, want[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random_stall;
    logic [NT*DW-1:0] w;
    logic [NT*DW-1:0] f;
    logic [AW-1:0] exp;
    int t;
    int c;
    int stalls;
    for (int i = 0; i < 16; i++) begin
      w = rand_vec();
      f = rand_vec();
      exp = ref_sum(w, f);
      send(w, f, t);
      c = 1;
      stalls = 0;
      while (result_valid !== 1'b1 && c < 80) begin
        en = ($urandom_range(0, 3) != 0);
        if (!en) stalls++;
        @(negedge clk);
        c++;
      end
      en = 1'b1;
      n_checks++;
      if (c !== 11 + stalls || result !== exp)
        $display("FAIL random%0d: got lat=%0d result=%h, want lat=%0d result=%h", i, c, result, 11 + stalls, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [NT*DW-1:0] w;
    logic [NT*DW-1:0] f;
    logic [AW-1:0] exp;
    int t;
    int c;
    w = rand_vec();
    f = rand_vec();
    exp = ref_sum(w, f);
    result_ready = 1'b0;
    send(w, f, t);
    wait_valid(c);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (result_valid !== 1'b1 || result !== exp || in_ready !== 1'b0 || c !== 11)
        $display("FAIL bp_hold%0d: got valid=%b result=%h in_ready=%b lat=%0d, want 1/%h/0/11",
                 i, result_valid, result, in_ready, c, exp);
      else n_pass++;
      @(negedge clk);
    end
    result_ready = 1'b1;
    n_checks++;
    if (result_valid !== 1'b1 || result !== exp)
      $display("FAIL bp_ready_cycle: got valid=%b result=%h, want 1/%h", result_valid, result, exp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp)
      $display("FAIL bp_idle: got valid=%b in_ready=%b result=%h, want 0/1/%h", result_valid, in_ready, result, exp);
    else n_pass++;
  endtask

  task automatic test_en_stall;
    logic [NT*DW-1:0] w;
    logic [NT*DW-1:0] f;
    logic [AW-1:0] exp;
    int t;
    int c;
    w = rand_vec();
    f = rand_vec();
    exp = ref_sum(w, f);
    send(w, f, t);
    c = 1;
    while (result_valid !== 1'b1 && c < 80) begin
      if (c == 4) begin
        n_checks++;
        if (mult_ce !== 1'b0 || mult_a !== w[2*DW +: DW] || mult_b !== f[2*DW +: DW])
          $display("FAIL stall_freeze: got ce=%b a=%h b=%h, want 0/%h/%h",
                   mult_ce, mult_a, mult_b, w[2*DW +: DW], f[2*DW +: DW]);
        else n_pass++;
      end
      en = !(c >= 3 && c <= 5);
      @(negedge clk);
      c++;
    end
    en = 1'b1;
    n_checks++;
    if (c !== 14 || result !== exp)
      $display("FAIL stall_result: got lat=%0d result=%h, want lat=14 result=%h", c, result, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [NT*DW-1:0] w;
    logic [NT*DW-1:0] f;
    int t;
    int c;
    w = rand_vec();
    f = rand_vec();
    send(w, f, t);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({result_valid, busy, mult_ce, mult_a, mult_b, result} !== '0)
      $display("FAIL rstmid_outputs: got valid=%b busy=%b ce=%b a=%h b=%h res=%h, want all 0",
               result_valid, busy, mult_ce, mult_a, mult_b, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || result !== '0)
      $display("FAIL rstmid_release: got in_ready=%b busy=%b valid=%b result=%h, want 1/0/0/0",
               in_ready, busy, result_valid, result);
    else n_pass++;
    for (int k = 0; k < NT; k++) begin
      w[k*DW +: DW] = DW'(k + 1);
      f[k*DW +: DW] = 8'd1;
    end
    send(w, f, t);
    wait_valid(c);
    n_checks++;
    if (c !== 11 || result !== 32'd45 || result !== ref_sum(w, f))
      $display("FAIL rstmid_fresh: got lat=%0d result=%0d, want lat=11 result=45", c, result);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [NT*DW-1:0] w;
    logic [NT*DW-1:0] f;
    logic [AW-1:0] exp;
    int t;
    int t_prev;
    int c;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      w = rand_vec();
      f = rand_vec();
      exp = ref_sum(w, f);
      send(w, f, t);
      if (i > 0) begin
        n_checks++;
        if (t - t_prev !== 12)
          $display("FAIL b2b_period%0d: got %0d cycles, want 12", i, t - t_prev);
        else n_pass++;
      end
      t_prev = t;
      wait_valid(c);
      n_checks++;
      if (result !== exp)
        $display("FAIL b2b_result%0d: got %h, want %h", i, result, exp);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_random_stall();
    test_backpressure();
    test_en_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
